// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter: operand/command in, result out.
interface pipelined_barrel_shifter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [SHAMT_WIDTH-1:0] shift_amt;
    logic [1:0]             mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   out_zero;

    modport master (
        output in_valid, data_in, shift_amt, mode, out_ready,
        input  in_ready, out_valid, data_out, out_zero
    );

    modport slave (
        input  in_valid, data_in, shift_amt, mode, out_ready,
        output in_ready, out_valid, data_out, out_zero
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log barrel shifter (LSL/LSR/ASR/ROR), one register per layer, valid/ready
// flow control that freezes the whole pipeline on backpressure.
module pipelined_barrel_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input logic                       clk,
    input logic                       rst,
    pipelined_barrel_shifter_if.slave bus
);
    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } op_e;

    function automatic logic [DATA_WIDTH-1:0] shift_layer(
        input logic [DATA_WIDTH-1:0] d,
        input op_e                   op,
        input int unsigned           s
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            LSL:     r = d << s;
            LSR:     r = d >> s;
            ASR:     r = $unsigned($signed(d) >>> s);
            default: r = (d >> s) | (d << (DATA_WIDTH - s));
        endcase
        return r;
    endfunction

    logic [DATA_WIDTH-1:0]  data_q  [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  data_d  [SHAMT_WIDTH];
    logic                   valid_q [SHAMT_WIDTH];
    logic                   valid_d [SHAMT_WIDTH];
    // The last stage needs no command copy, so mode/amount stop one stage short.
    logic [1:0]             mode_q  [SHAMT_WIDTH-1];
    logic [1:0]             mode_d  [SHAMT_WIDTH-1];
    logic [SHAMT_WIDTH-1:0] amt_q   [SHAMT_WIDTH-1];
    logic [SHAMT_WIDTH-1:0] amt_d   [SHAMT_WIDTH-1];
    logic                   zero_q;
    logic                   advance;

    for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_layer
        logic [DATA_WIDTH-1:0]  src_data;
        logic [1:0]             src_mode;
        logic [SHAMT_WIDTH-1:0] src_amt;
        logic                   src_valid;

        if (k == 0) begin : g_head
            assign src_data  = bus.data_in;
            assign src_mode  = bus.mode;
            assign src_amt   = bus.shift_amt;
            assign src_valid = bus.in_valid;
        end else begin : g_body
            assign src_data  = data_q[k-1];
            assign src_mode  = mode_q[k-1];
            assign src_amt   = amt_q[k-1];
            assign src_valid = valid_q[k-1];
        end

        assign data_d[k]  = src_amt[k] ? shift_layer(src_data, op_e'(src_mode), 32'(1) << k)
                                       : src_data;
        assign valid_d[k] = src_valid;

        if (k < SHAMT_WIDTH - 1) begin : g_carry
            assign mode_d[k] = src_mode;
            assign amt_d[k]  = src_amt;
        end
    end

    assign advance = !valid_q[SHAMT_WIDTH-1] || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SHAMT_WIDTH; k++) begin
                data_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end
            for (int unsigned k = 0; k < SHAMT_WIDTH - 1; k++) begin
                mode_q[k] <= '0;
                amt_q[k]  <= '0;
            end
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < SHAMT_WIDTH; k++) begin
                data_q[k]  <= data_d[k];
                valid_q[k] <= valid_d[k];
            end
            for (int unsigned k = 0; k < SHAMT_WIDTH - 1; k++) begin
                mode_q[k] <= mode_d[k];
                amt_q[k]  <= amt_d[k];
            end
            zero_q <= (data_d[SHAMT_WIDTH-1] == '0);
        end
    end

    // Outputs are forced to their idle values while reset is held, before the
    // synchronous clear has taken effect.
    assign bus.in_ready  = rst || advance;
    assign bus.out_valid = !rst && valid_q[SHAMT_WIDTH-1];
    assign bus.data_out  = rst ? '0 : data_q[SHAMT_WIDTH-1];
    assign bus.out_zero  = !rst && zero_q;
endmodule
